uart_rx: RTL
============

# uart_rx

Serial receive front end for the UART. It samples the asynchronous `Rx` line, de-frames start/data/parity/stop bits, and checks parity and framing. Each character is presented with a one-cycle `Data_Rdy`-style strobe to the receive FIFO directly downstream, together with a per-character error code. That FIFO supplies `Data_Out`, `FIFO_Empty`, `FIFO_Full` and `FIFO_Overflow` to the rest of the UART.

## Interface
Parameters:
- `SYSCLK_RATE`, 100000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bits/s.
- `DATA_BITS`, 8: data bits per character, LSB first.
- `PARITY_BIT`, 1: 1 means an even-parity bit follows the data; 0 means no parity bit.
- `STOP_BITS`, 2: number of stop bits checked, 1 or 2.

Ports:
- `SysClk`, in, 1: single clock. All logic is on the rising edge.
- `Rst`, in, 1: reset. Asynchronous, active-low.
- `Rx`, in, 1: serial line, asynchronous, idle high.
- `FIFO_Full`, in, 1: full flag from the downstream receive FIFO.
- `Rx_Data`, out, `DATA_BITS`: last received character.
- `Rx_Valid`, out, 1: one-cycle strobe marking a new `Rx_Data`/`Rx_Error`.
- `Rx_Error`, out, 3: error code for the character. [0] parity, [1] framing, [2] overrun.
- `Rx_Busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- Bit timing:
  - `CLKS_PER_BIT` = `SYSCLK_RATE / BAUD_RATE`, integer division, truncated.
  - `HALF_BIT` = `CLKS_PER_BIT / 2`.
  - Bit counter width = clog2(`CLKS_PER_BIT`).
- Synchronizer: `Rx` passes through a 2-flop synchronizer that resets to 1. The result is `rx_s`. All decisions use `rx_s`.
- FSM states and transitions:
  - IDLE -> START when `rx_s` falls (1 then 0).
  - START: sample at `HALF_BIT`.
    - Sample = 1: false start. Return to IDLE with no strobe and no error.
    - Sample = 0: go to DATA.
  - DATA: `DATA_BITS` samples, each `CLKS_PER_BIT` after the previous one. Shift LSB first.
  - PARITY: one sample, taken only if `PARITY_BIT` = 1. Error if XOR(data, parity) != 0.
  - STOP: `STOP_BITS` samples. Any sample of 0 sets the framing error.
  - DONE: one cycle.
    - Drive `Rx_Valid` = 1.
    - Load `Rx_Data` and `Rx_Error`.
    - `Rx_Error[2]` = `FIFO_Full` sampled in this cycle.
    - Go to IDLE if the framing error is clear, otherwise to BREAKWAIT.
  - BREAKWAIT: hold until `rx_s` = 1, then go to IDLE. This prevents a low line from being taken as a new start.
- Outputs hold:
  - `Rx_Data` and `Rx_Error` hold until the next DONE.
  - A character is still delivered when any error bit is set.
  - Overrun does not drop the strobe; the FIFO decides.
- Reset values: `Rx_Data` = 0, `Rx_Valid` = 0, `Rx_Error` = 0, `Rx_Busy` = 0, FSM = IDLE, synchronizer = 2'b11.
- Reset mid-frame: asynchronous abort to IDLE. The partial character is discarded. After release, the next character starts only on a fresh falling edge.

## Timing
- Let t0 be the first cycle with `rx_s` = 0.
- Sample k is taken at t0 + `HALF_BIT` + k·`CLKS_PER_BIT`, where k = 0 is the start bit.
- `Rx_Valid` is high in the cycle after the last stop sample:
  - t0 + `HALF_BIT` + (`DATA_BITS` + `PARITY_BIT` + `STOP_BITS`)·`CLKS_PER_BIT` + 1.
  - Add 2 cycles from the pin for the synchronizer.
- Return to IDLE occurs mid-way through the last stop bit. A following start edge is therefore caught with at most 1 cycle of skew, and back-to-back frames need no gap.
- `Rx_Busy` rises the cycle after t0 and falls with the entry to IDLE.
- `FIFO_Full` is the only timing-relevant input besides `Rx`. It is sampled in the DONE cycle only.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN`:
  - Defined: each bit value is the 2-of-3 majority of `rx_s` at sample point −1, 0 and +1. Decisions, and hence `Rx_Valid`, move 1 cycle later. The false-start check also uses the vote.
  - Undefined: single sample at the sample point, with the latency above.

## Test plan
Bench settings: `SYSCLK_RATE` = 1600, `BAUD_RATE` = 100 (`CLKS_PER_BIT` = 16), `DATA_BITS` = 8, `PARITY_BIT` = 1, `STOP_BITS` = 2.
- Frame 0xA5, parity 0, stop 1,1 -> one `Rx_Valid` pulse, `Rx_Data` = 8'hA5, `Rx_Error` = 3'b000, at exactly the computed cycle.
- Frame 0x3C with parity bit = 1 (wrong) -> `Rx_Data` = 8'h3C, `Rx_Error` = 3'b001.
- Frame 0x55 with first stop = 0, line then held low for 5 bit times -> `Rx_Error` = 3'b010, then no further `Rx_Valid`. After the line goes high, frame 0x81 -> `Rx_Data` = 8'h81, `Rx_Error` = 0.
- 4-cycle low glitch on idle `Rx` -> `Rx_Busy` pulses, `Rx_Valid` stays 0, FSM returns to IDLE.
- Frames 0x12 and 0x34 back-to-back with `FIFO_Full` = 1 during the second DONE -> first `Rx_Error` = 3'b000, second `Rx_Data` = 8'h34 with `Rx_Error` = 3'b100.
- `Rst` low during data bit 3 of 0xFF -> all outputs 0 immediately. After release, frame 0x0F -> `Rx_Data` = 8'h0F, `Rx_Error` = 0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receive front end: 2-flop synchronizer, start/data/parity/stop de-framing, error flags.
// Optional UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around each sample point, one cycle later.
module uart_rx #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_BIT  = 1,
  parameter int STOP_BITS   = 2
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 FIFO_Full,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  output logic [2:0]           Rx_Error,
  output logic                 Rx_Busy
);

  localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int FIRST_TICK   = HALF_BIT;
`else
  localparam int FIRST_TICK   = HALF_BIT - 1;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, BREAKWAIT} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           sync_reg;
  logic                 rx_s, rx_prev_reg, bit_val;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next, data_reg;
  logic                 par_reg, par_next, frm_reg, frm_next;
  logic [2:0]           err_reg;
  logic                 tick_half, tick_bit;

  assign rx_s = sync_reg[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_reg;
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) hist_reg <= 2'b11;
    else      hist_reg <= {hist_reg[0], rx_s};
  end
  // Tick lands on sample point +1: rx_s is +1, hist[0] is 0, hist[1] is -1.
  assign bit_val = (rx_s & hist_reg[0]) | (rx_s & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);
`else
  assign bit_val = rx_s;
`endif

  assign tick_half = (cnt_reg == CNT_W'(FIRST_TICK));
  assign tick_bit  = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      state_reg   <= IDLE;
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
      frm_reg     <= 1'b0;
      data_reg    <= '0;
      err_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      sync_reg    <= {sync_reg[0], Rx};
      rx_prev_reg <= rx_s;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      frm_reg     <= frm_next;
      if (state_reg == DONE) begin
        data_reg <= shift_reg;
        err_reg  <= {FIFO_Full, frm_reg, par_reg};
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    frm_next   = frm_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_prev_reg && !rx_s) begin
          state_next = START;
          idx_next   = '0;
          par_next   = 1'b0;
          frm_next   = 1'b0;
        end
      end
      START: begin
        if (tick_half) begin
          cnt_next   = '0;
          state_next = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_bit) begin
          cnt_next   = '0;
          shift_next = {bit_val, shift_reg[DATA_BITS-1:1]};
          if (idx_reg == IDX_W'(DATA_BITS - 1)) begin
            idx_next   = '0;
            state_next = (PARITY_BIT != 0) ? PARITY : STOP;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick_bit) begin
          cnt_next   = '0;
          par_next   = (^shift_reg) ^ bit_val;
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick_bit) begin
          cnt_next = '0;
          if (!bit_val) frm_next = 1'b1;
          if (idx_reg == IDX_W'(STOP_BITS - 1)) state_next = DONE;
          else idx_next = idx_reg + IDX_W'(1);
        end
      end
      DONE:      state_next = frm_reg ? BREAKWAIT : IDLE;
      BREAKWAIT: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // During DONE the fresh character and live FIFO_Full are presented alongside the strobe.
  assign Rx_Valid = (state_reg == DONE);
  assign Rx_Busy  = (state_reg != IDLE);
  assign Rx_Data  = Rx_Valid ? shift_reg : data_reg;
  assign Rx_Error = Rx_Valid ? {FIFO_Full, frm_reg, par_reg} : err_reg;

endmodule
